rv_wb_arbiter: RTL and testbench

Writeback-side owner of the register file write port in the rv32i pipeline. It merges ALU results (handshaked) and load responses (unstallable, variable latency) onto the single regfile write port, buffering ALU results in a 2-entry FIFO on collision. It keeps a pending-load scoreboard and reports per-read-port busy flags to decode, so decode never reads a register whose newest value has not yet been written.

---
 rtl/rv_wb_arbiter.sv | 149 ++++++++++++++
 tb/tb_rv_wb_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/rv_wb_arbiter.sv
// Writeback arbiter: merges load responses and ALU results onto the single
// regfile write port, with a 2-entry ALU FIFO and a pending-load scoreboard.
module rv_wb_arbiter #(
    parameter int unsigned XLEN = 32
) (
    input  logic            i_wb_clk,
    input  logic            i_wb_rstn,
    input  logic            i_wb_alu_valid,
    input  logic [4:0]      i_wb_alu_rd,
    input  logic [XLEN-1:0] i_wb_alu_data,
    output logic            o_wb_alu_ready,
    input  logic            i_wb_ld_issue,
    input  logic [4:0]      i_wb_ld_issue_rd,
    input  logic            i_wb_ld_valid,
    input  logic [4:0]      i_wb_ld_rd,
    input  logic [XLEN-1:0] i_wb_ld_data,
    input  logic [4:0]      i_wb_raddr [1:2],
    output logic            o_wb_busy  [1:2],
    output logic            o_wb_rf_wen,
    output logic [4:0]      o_wb_rf_waddr,
    output logic [XLEN-1:0] o_wb_rf_wdata
);

    localparam int unsigned DEPTH = 2;
    localparam int unsigned AW    = 5;
    localparam int unsigned CW    = 2;
    localparam int unsigned NREG  = 32;

    logic [DEPTH-1:0] fifo_v;
    logic [AW-1:0]    fifo_rd   [DEPTH];
    logic [XLEN-1:0]  fifo_data [DEPTH];
    logic             head;
    logic             tail;
    logic [CW-1:0]    count;
    logic [NREG-1:0]  sb;
    logic [NREG-1:0]  sb_next;

    logic            fifo_empty;
    logic            fifo_room;
    logic            ld_wr;
    logic            pop;
    logic            bypass;
    logic            push;
    logic            wen_c;
    logic [AW-1:0]   waddr_c;
    logic [XLEN-1:0] wdata_c;

    // Arbitration decisions for this cycle
    always_comb begin
        fifo_empty = (count == CW'(0));
        fifo_room  = (count < CW'(DEPTH));
        ld_wr      = i_wb_ld_valid && (i_wb_ld_rd != AW'(0));
        pop        = !i_wb_ld_valid && !fifo_empty;
        bypass     = !i_wb_ld_valid && fifo_empty && i_wb_alu_valid
                     && (i_wb_alu_rd != AW'(0));
        // rd=0 results are accepted but never occupy a FIFO slot
        push       = i_wb_alu_valid && fifo_room && !bypass
                     && (i_wb_alu_rd != AW'(0));
    end

    // Write-port mux: load response, then FIFO head, then ALU bypass
    always_comb begin
        wen_c   = 1'b0;
        waddr_c = '0;
        wdata_c = '0;
        if (i_wb_ld_valid) begin
            wen_c   = ld_wr;
            waddr_c = i_wb_ld_rd;
            wdata_c = i_wb_ld_data;
        end else if (pop) begin
            wen_c   = fifo_v[head] && (fifo_rd[head] != AW'(0));
            waddr_c = fifo_rd[head];
            wdata_c = fifo_data[head];
        end else if (bypass) begin
            wen_c   = 1'b1;
            waddr_c = i_wb_alu_rd;
            wdata_c = i_wb_alu_data;
        end
    end

    // Set wins over clear when a load issues to the rd its response retires
    always_comb begin
        sb_next = sb;
        if (ld_wr) begin
            sb_next[i_wb_ld_rd] = 1'b0;
        end
        if (i_wb_ld_issue && (i_wb_ld_issue_rd != AW'(0))) begin
            sb_next[i_wb_ld_issue_rd] = 1'b1;
        end
        sb_next[0] = 1'b0;
    end

    // Port outputs are forced quiet while reset is held
    always_comb begin
        o_wb_alu_ready = i_wb_rstn && fifo_room;
        o_wb_rf_wen    = i_wb_rstn && wen_c;
        o_wb_rf_waddr  = i_wb_rstn ? waddr_c : '0;
        o_wb_rf_wdata  = i_wb_rstn ? wdata_c : '0;
    end

    // Busy: pending load, buffered ALU result, or a write landing this cycle
    always_comb begin
        for (int n = 1; n <= 2; n++) begin
            logic hit;
            hit = sb[i_wb_raddr[n]]
                  || (wen_c && (waddr_c == i_wb_raddr[n]));
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (fifo_v[i] && (fifo_rd[i] == i_wb_raddr[n])) begin
                    hit = 1'b1;
                end
            end
            o_wb_busy[n] = i_wb_rstn && (i_wb_raddr[n] != AW'(0)) && hit;
        end
    end

    // FIFO and scoreboard state; a load write supersedes buffered entries
    always_ff @(posedge i_wb_clk) begin
        if (!i_wb_rstn) begin
            fifo_v <= '0;
            head   <= 1'b0;
            tail   <= 1'b0;
            count  <= '0;
            sb     <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_rd[i]   <= '0;
                fifo_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (ld_wr && (fifo_rd[i] == i_wb_ld_rd)) begin
                    fifo_v[i] <= 1'b0;
                end
            end
            if (pop) begin
                fifo_v[head] <= 1'b0;
                head         <= ~head;
            end
            if (push) begin
                fifo_v[tail]    <= 1'b1;
                fifo_rd[tail]   <= i_wb_alu_rd;
                fifo_data[tail] <= i_wb_alu_data;
                tail            <= ~tail;
            end
            count <= count + CW'(push) - CW'(pop);
            sb    <= sb_next;
        end
    end

endmodule

// File: tb/tb_rv_wb_arbiter.sv
// Directed bench for rv_wb_arbiter: bypass, collision buffering, scoreboard,
// load supersession, rd=0 handling and mid-operation reset.
module tb_rv_wb_arbiter;

    logic        clk;
    logic        rstn;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        ld_issue;
    logic [4:0]  ld_issue_rd;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic [4:0]  raddr [1:2];
    logic        busy  [1:2];
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] shadow_rf [32];
    logic [31:0] bench_sb;

    rv_wb_arbiter #(.XLEN(32)) dut (
        .i_wb_clk         (clk),
        .i_wb_rstn        (rstn),
        .i_wb_alu_valid   (alu_valid),
        .i_wb_alu_rd      (alu_rd),
        .i_wb_alu_data    (alu_data),
        .o_wb_alu_ready   (alu_ready),
        .i_wb_ld_issue    (ld_issue),
        .i_wb_ld_issue_rd (ld_issue_rd),
        .i_wb_ld_valid    (ld_valid),
        .i_wb_ld_rd       (ld_rd),
        .i_wb_ld_data     (ld_data),
        .i_wb_raddr       (raddr),
        .o_wb_busy        (busy),
        .o_wb_rf_wen      (rf_wen),
        .o_wb_rf_waddr    (rf_waddr),
        .o_wb_rf_wdata    (rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Regfile image built from observed writes; issue-legality guard on stimulus
    always @(posedge clk) begin
        if (rf_wen) shadow_rf[rf_waddr] <= rf_wdata;
        if (!rstn) begin
            bench_sb <= '0;
        end else begin
            if (ld_issue && ld_issue_rd != 5'd0) begin
                assert (!bench_sb[ld_issue_rd] || (ld_valid && ld_rd == ld_issue_rd))
                    else $error("illegal issue to pending rd %0d", ld_issue_rd);
            end
            if (ld_valid && ld_rd != 5'd0) bench_sb[ld_rd] <= 1'b0;
            if (ld_issue && ld_issue_rd != 5'd0) bench_sb[ld_issue_rd] <= 1'b1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ld_issue = 1'b0; ld_issue_rd = '0;
        ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
    endtask

    task automatic check_write(input string tag, input logic wen, input logic [4:0] wa,
                               input logic [31:0] wd);
        #1;
        check_eq({tag, "_wen"}, 32'(rf_wen), 32'(wen));
        if (wen) begin
            check_eq({tag, "_waddr"}, 32'(rf_waddr), 32'(wa));
            check_eq({tag, "_wdata"}, rf_wdata, wd);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) shadow_rf[i] = '0;
        idle();
        raddr[1] = '0; raddr[2] = '0;
        rstn = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd5; ld_valid = 1'b1; ld_rd = 5'd6;
        #2;
        check_eq("rst_ready", 32'(alu_ready), 32'd0);
        check_eq("rst_wen", 32'(rf_wen), 32'd0);
        tick(); tick();

        // Bypass straight to the port
        rstn = 1'b1; idle();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h11;
        check_write("bypass", 1'b1, 5'd5, 32'h11);
        check_eq("bypass_ready", 32'(alu_ready), 32'd1);
        tick(); idle();
        check_write("bypass_empty", 1'b0, '0, '0);

        // Load collides with ALU for three cycles
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'hAA;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h31;
        check_write("col_c0", 1'b1, 5'd7, 32'hAA);
        check_eq("col_c0_ready", 32'(alu_ready), 32'd1);
        tick(); alu_data = 32'h32;
        check_write("col_c1", 1'b1, 5'd7, 32'hAA);
        check_eq("col_c1_ready", 32'(alu_ready), 32'd1);
        tick(); alu_data = 32'h33;
        check_write("col_c2", 1'b1, 5'd7, 32'hAA);
        check_eq("col_c2_ready", 32'(alu_ready), 32'd0);
        tick(); ld_valid = 1'b0;
        check_write("drain0", 1'b1, 5'd3, 32'h31);
        check_eq("drain0_ready", 32'(alu_ready), 32'd0);
        tick();
        check_write("drain1", 1'b1, 5'd3, 32'h32);
        check_eq("drain1_ready", 32'(alu_ready), 32'd1);
        tick(); idle(); raddr[1] = 5'd3;
        check_write("drain2", 1'b1, 5'd3, 32'h33);
        check_eq("drain2_busy3", 32'(busy[1]), 32'd1);
        tick();
        check_write("drain_done", 1'b0, '0, '0);
        check_eq("drain_done_busy3", 32'(busy[1]), 32'd0);

        // Scoreboard set/clear and same-cycle set-wins
        raddr[1] = 5'd9;
        ld_issue = 1'b1; ld_issue_rd = 5'd9;
        #1 check_eq("sb_issue_same", 32'(busy[1]), 32'd0);
        tick(); idle();
        #1 check_eq("sb_pending", 32'(busy[1]), 32'd1);
        ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h99;
        check_write("sb_resp", 1'b1, 5'd9, 32'h99);
        check_eq("sb_resp_busy", 32'(busy[1]), 32'd1);
        tick(); idle();
        #1 check_eq("sb_cleared", 32'(busy[1]), 32'd0);
        ld_issue = 1'b1; ld_issue_rd = 5'd9;
        tick(); idle();
        ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h9A;
        ld_issue = 1'b1; ld_issue_rd = 5'd9;
        check_write("sb_setclr", 1'b1, 5'd9, 32'h9A);
        tick(); idle();
        #1 check_eq("sb_set_wins", 32'(busy[1]), 32'd1);
        ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h9B;
        tick(); idle();
        #1 check_eq("sb_final_clear", 32'(busy[1]), 32'd0);

        // Load supersedes a buffered ALU result to the same rd
        raddr[2] = 5'd4;
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h77;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h1;
        tick(); idle();
        ld_valid = 1'b1; ld_rd = 5'd4; ld_data = 32'h2;
        check_write("sup_load", 1'b1, 5'd4, 32'h2);
        check_eq("sup_busy_now", 32'(busy[2]), 32'd1);
        tick(); idle();
        check_write("sup_pop", 1'b0, '0, '0);
        check_eq("sup_busy_after", 32'(busy[2]), 32'd0);
        tick();
        check_eq("sup_reg4", shadow_rf[4], 32'h2);

        // rd/raddr zero
        raddr[1] = 5'd0; raddr[2] = 5'd0;
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h5A;
        ld_issue = 1'b1; ld_issue_rd = 5'd0;
        check_write("zero_alu", 1'b0, '0, '0);
        check_eq("zero_alu_ready", 32'(alu_ready), 32'd1);
        check_eq("zero_busy", 32'(busy[1]), 32'd0);
        tick(); idle();
        ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h55;
        check_write("zero_ld", 1'b0, '0, '0);
        tick(); idle();
        check_write("zero_after", 1'b0, '0, '0);

        // Fill state, then reset mid-operation
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h70;
        alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hA;
        ld_issue = 1'b1; ld_issue_rd = 5'd12;
        tick();
        ld_issue = 1'b0; ld_data = 32'h71; alu_rd = 5'd11; alu_data = 32'hB;
        tick(); idle();
        raddr[1] = 5'd10; raddr[2] = 5'd12;
        #1;
        check_eq("pre_rst_busy10", 32'(busy[1]), 32'd1);
        check_eq("pre_rst_busy12", 32'(busy[2]), 32'd1);
        check_eq("pre_rst_ready", 32'(alu_ready), 32'd0);
        rstn = 1'b0;
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h7F;
        alu_valid = 1'b1; alu_rd = 5'd13;
        #1;
        check_eq("rst_mid_ready", 32'(alu_ready), 32'd0);
        check_eq("rst_mid_wen", 32'(rf_wen), 32'd0);
        check_eq("rst_mid_waddr", 32'(rf_waddr), 32'd0);
        check_eq("rst_mid_wdata", rf_wdata, 32'd0);
        check_eq("rst_mid_busy1", 32'(busy[1]), 32'd0);
        check_eq("rst_mid_busy2", 32'(busy[2]), 32'd0);
        tick();
        rstn = 1'b1; idle();
        #1;
        check_eq("post_rst_ready", 32'(alu_ready), 32'd1);
        check_eq("post_rst_busy10", 32'(busy[1]), 32'd0);
        check_eq("post_rst_busy12", 32'(busy[2]), 32'd0);
        check_eq("post_rst_wen", 32'(rf_wen), 32'd0);
        tick();
        check_eq("post_rst_wen2", 32'(rf_wen), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
